// File: rtl/hdmi_pkg.sv
// Shared constants and helpers for the HDMI output path: FSM encoding,
// line geometry and the busy-handshake timeout.
package hdmi_pkg;

    localparam int DEF_X_SIZE   = 1280;
    localparam int DEF_Y_SIZE   = 720;
    localparam int DEF_BPP      = 4;
    localparam int BUSY_TIMEOUT = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    function automatic int line_words(input int x_size, input int bpp);
        return x_size * bpp / 4;
    endfunction

    function automatic int line_bytes(input int x_size, input int bpp);
        return line_words(x_size, bpp) * 4;
    endfunction

endpackage

// File: rtl/hdmi_burst_split.sv
// Splits one line into bursts of at most MAX_BURST words; exposes the offset
// and length of the burst that follows the current done/clear decision.
module hdmi_burst_split
    import hdmi_pkg::*;
#(
    parameter int LINE_WORDS = DEF_X_SIZE * DEF_BPP / 4,
    parameter int MAX_BURST  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        done,
    output logic        last,
    output logic [31:0] nxt_off,
    output logic [31:0] nxt_num
);

    localparam logic [31:0] LW = 32'(LINE_WORDS);
    localparam logic [31:0] MB = 32'(MAX_BURST);

    logic [31:0] word_off;
    logic [31:0] cur_num;

    function automatic logic [31:0] burst_len(input logic [31:0] off);
        logic [31:0] rem;
        rem = LW - off;
        return (rem < MB) ? rem : MB;
    endfunction

    assign cur_num = burst_len(word_off);
    assign last    = (word_off + cur_num) >= LW;
    assign nxt_num = burst_len(nxt_off);

    always_comb begin
        nxt_off = word_off;
        if (clear)
            nxt_off = '0;
        else if (done)
            nxt_off = word_off + cur_num;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            word_off <= '0;
        else
            word_off <= nxt_off;
    end

endmodule

// File: rtl/hdmi_frame_fetcher.sv
// DRAM read scheduler for HDMI scan-out: turns framestart/prefetch_line pulses
// into chunked kick/read_addr/read_num requests with N-buffer frame rotation.
module hdmi_frame_fetcher
    import hdmi_pkg::*;
#(
    parameter int          X_SIZE       = DEF_X_SIZE,
    parameter int          Y_SIZE       = DEF_Y_SIZE,
    parameter int          BPP          = DEF_BPP,
    parameter int          MAX_BURST    = 256,
    parameter int          NUM_FRAMES   = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        framestart,
    input  logic        prefetch_line,
    input  logic        wr_frame_done,
    input  logic [1:0]  wr_frame,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    output logic [1:0]  cur_frame,
    output logic [11:0] line_idx,
    output logic        overrun
);

    localparam int          LINE_WORDS = line_words(X_SIZE, BPP);
    localparam logic [31:0] LINE_BYTES = 32'(line_bytes(X_SIZE, BPP));
    localparam logic [11:0] Y_LIM      = 12'(Y_SIZE);
    localparam logic [3:0]  TMO_LAST   = 4'(BUSY_TIMEOUT - 1);

    logic [1:0]  state;
    logic [3:0]  hi_cnt;
    logic        pending;
    logic        abort_line;
    logic        done_seen;
    logic [1:0]  latest_done;
    logic        wr_ok;
    logic        line_ok;
    logic        burst_done;
    logic        split_clear;
    logic        last_burst;
    logic [31:0] nxt_off;
    logic [31:0] nxt_num;

    function automatic logic [31:0] burst_addr(input logic [1:0] frame,
                                               input logic [11:0] line,
                                               input logic [31:0] off);
        return BASE_ADDR + 32'(frame) * FRAME_STRIDE + 32'(line) * LINE_BYTES + (off << 2);
    endfunction

    assign wr_ok       = wr_frame_done && ({30'd0, wr_frame} < 32'(NUM_FRAMES));
    assign line_ok     = line_idx < Y_LIM;
    assign burst_done  = (state == ST_WAIT_LO) && !busy;
    assign split_clear = burst_done && (framestart || abort_line || last_burst);
    assign kick        = (state == ST_ISSUE);

    hdmi_burst_split #(
        .LINE_WORDS (LINE_WORDS),
        .MAX_BURST  (MAX_BURST)
    ) u_split (
        .clk     (clk),
        .rst     (rst),
        .clear   (split_clear),
        .done    (burst_done),
        .last    (last_burst),
        .nxt_off (nxt_off),
        .nxt_num (nxt_num)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hi_cnt      <= '0;
            pending     <= 1'b0;
            abort_line  <= 1'b0;
            done_seen   <= 1'b0;
            latest_done <= '0;
            read_addr   <= '0;
            read_num    <= '0;
            cur_frame   <= '0;
            line_idx    <= '0;
            overrun     <= 1'b0;
        end else begin
            if (wr_ok) begin
                latest_done <= wr_frame;
                done_seen   <= 1'b1;
            end

            // framestart wins over a coincident prefetch and re-arms line 0
            if (framestart) begin
                line_idx  <= '0;
                pending   <= 1'b1;
                done_seen <= 1'b0;
                if (wr_ok)
                    cur_frame <= wr_frame;
                else if (done_seen)
                    cur_frame <= latest_done;
            end else if (prefetch_line && line_ok) begin
                if (pending)
                    overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pending && line_ok && !framestart) begin
                        state     <= ST_ISSUE;
                        read_addr <= burst_addr(cur_frame, line_idx, nxt_off);
                        read_num  <= nxt_num;
                    end
                end
                ST_ISSUE: begin
                    state  <= ST_WAIT_HI;
                    hi_cnt <= '0;
                    if (framestart)
                        abort_line <= 1'b1;
                end
                ST_WAIT_HI: begin
                    if (framestart)
                        abort_line <= 1'b1;
                    // a reader that finishes without ever raising busy still releases us
                    if (busy || hi_cnt == TMO_LAST)
                        state <= ST_WAIT_LO;
                    else
                        hi_cnt <= hi_cnt + 4'd1;
                end
                ST_WAIT_LO: begin
                    if (!busy) begin
                        abort_line <= 1'b0;
                        if (framestart || abort_line) begin
                            state <= ST_IDLE;
                        end else if (last_burst) begin
                            state    <= ST_IDLE;
                            line_idx <= line_idx + 12'd1;
                            pending  <= 1'b0;
                        end else begin
                            state     <= ST_ISSUE;
                            read_addr <= burst_addr(cur_frame, line_idx, nxt_off);
                            read_num  <= nxt_num;
                        end
                    end else if (framestart) begin
                        abort_line <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_frame_fetcher.sv
// Directed bench for hdmi_frame_fetcher: a burst-list model per instance is
// checked on every kick, plus literal timing/address checks per scenario.
module tb_hdmi_frame_fetcher;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] num;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_a, pf_a, wd_a, kick_a, busy_a, ov_a;
    logic [1:0]  wf_a, cf_a;
    logic [31:0] addr_a, num_a;
    logic [11:0] li_a;
    logic        fs_b, pf_b, wd_b, kick_b, busy_b, ov_b;
    logic [1:0]  wf_b, cf_b;
    logic [31:0] addr_b, num_b;
    logic [11:0] li_b;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_a = 0;
    int rd_b = 0;
    bit never_a = 0;
    bit hold_a = 0;

    burst_t      exp_a[$];
    burst_t      exp_b[$];
    logic [31:0] log_addr_a[$];
    logic [31:0] log_num_a[$];
    int          log_cyc_a[$];
    logic [31:0] log_addr_b[$];
    logic [31:0] log_num_b[$];

    hdmi_frame_fetcher #(
        .X_SIZE(1280), .Y_SIZE(720), .BPP(4), .MAX_BURST(256), .NUM_FRAMES(2),
        .BASE_ADDR(32'h0), .FRAME_STRIDE(32'h0040_0000)
    ) u_a (
        .clk(clk), .rst(rst), .framestart(fs_a), .prefetch_line(pf_a),
        .wr_frame_done(wd_a), .wr_frame(wf_a), .kick(kick_a), .busy(busy_a),
        .read_addr(addr_a), .read_num(num_a), .cur_frame(cf_a),
        .line_idx(li_a), .overrun(ov_a)
    );

    hdmi_frame_fetcher #(
        .X_SIZE(1280), .Y_SIZE(4), .BPP(2), .MAX_BURST(256), .NUM_FRAMES(1),
        .BASE_ADDR(32'h0), .FRAME_STRIDE(32'h0040_0000)
    ) u_b (
        .clk(clk), .rst(rst), .framestart(fs_b), .prefetch_line(pf_b),
        .wr_frame_done(wd_b), .wr_frame(wf_b), .kick(kick_b), .busy(busy_b),
        .read_addr(addr_b), .read_num(num_b), .cur_frame(cf_b),
        .line_idx(li_b), .overrun(ov_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM reader stand-ins: busy for 10 cycles after each kick
    always @(posedge clk) begin
        if (kick_a && !never_a) rd_a <= 10;
        else if (rd_a > 0)      rd_a <= rd_a - 1;
        if (kick_b)             rd_b <= 10;
        else if (rd_b > 0)      rd_b <= rd_b - 1;
    end
    assign busy_a = hold_a || (rd_a > 0);
    assign busy_b = (rd_b > 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired, want DUT event", name);
    endtask

    task automatic push_one(input bit b, input logic [31:0] addr, input logic [31:0] num);
        burst_t e;
        e.addr = addr;
        e.num  = num;
        if (b) exp_b.push_back(e); else exp_a.push_back(e);
    endtask

    // Whole line in MAX_BURST-word pieces, straight from the address formula
    task automatic push_line(input bit b, input int frame, input int line);
        int bpp, lw, off, n;
        bpp = b ? 2 : 4;
        lw  = 1280 * bpp / 4;
        off = 0;
        while (off < lw) begin
            n = (lw - off < 256) ? lw - off : 256;
            push_one(b, 32'(frame) * 32'h0040_0000 + 32'(line * lw * 4) + 32'(off * 4), 32'(n));
            off += n;
        end
    endtask

    task automatic pulse(input bit b, input bit fs, input bit pf, input bit wd, input logic [1:0] wf);
        @(posedge clk); #1;
        if (b) begin fs_b = fs; pf_b = pf; wd_b = wd; wf_b = wf; end
        else   begin fs_a = fs; pf_a = pf; wd_a = wd; wf_a = wf; end
        @(posedge clk); #1;
        fs_a = 0; pf_a = 0; wd_a = 0; wf_a = 0;
        fs_b = 0; pf_b = 0; wd_b = 0; wf_b = 0;
    endtask

    task automatic wait_kick(input bit b, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (b ? kick_b : kick_a) begin
                n = i;
                break;
            end
        end
        if (n == 0) bound_fail("wait_kick");
    endtask

    task automatic drain(input bit b, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b ? (exp_b.size() == 0 && rd_b == 0 && !kick_b)
                  : (exp_a.size() == 0 && rd_a == 0 && !kick_a && !hold_a)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail(b ? "drain_b" : "drain_a");
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        burst_t e;
        if (rst && kick_a) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL kick_a_unexpected: got addr 0x%08h, want no kick", addr_a);
            end else begin
                e = exp_a.pop_front();
                chk("kick_a_addr", addr_a, e.addr);
                chk("kick_a_num", num_a, e.num);
            end
            log_addr_a.push_back(addr_a);
            log_num_a.push_back(num_a);
            log_cyc_a.push_back(cyc);
        end
        if (rst && kick_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL kick_b_unexpected: got addr 0x%08h, want no kick", addr_b);
            end else begin
                e = exp_b.pop_front();
                chk("kick_b_addr", addr_b, e.addr);
                chk("kick_b_num", num_b, e.num);
            end
            log_addr_b.push_back(addr_b);
            log_num_b.push_back(num_b);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        rst = 0;
        fs_a = 0; pf_a = 0; wd_a = 0; wf_a = 0;
        fs_b = 0; pf_b = 0; wd_b = 0; wf_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kick", 32'(kick_a), 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_num", num_a, 0);
        chk("rst_frame", 32'(cf_a), 0);
        chk("rst_line", 32'(li_a), 0);
        chk("rst_overrun", 32'(ov_a), 0);
        rst = 1;

        // Line 0 of frame 0: five 256-word bursts
        k = log_addr_a.size();
        push_line(0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        wait_kick(0, 10, n);
        chk("t1_latency", 32'(n), 2);
        drain(0, 200);
        chk("t1_addr0", log_addr_a[k], 32'h0);
        chk("t1_addr4", log_addr_a[k+4], 32'h1000);
        chk("t1_num4", log_num_a[k+4], 32'd256);
        chk("t1_gap", 32'(log_cyc_a[k+1] - log_cyc_a[k]), 12);
        chk("t1_line", 32'(li_a), 1);

        // Writer finishes buffer 1 mid-frame; only the next framestart switches
        push_line(0, 0, 1);
        pulse(0, 0, 1, 0, 0);
        repeat (20) @(negedge clk);
        pulse(0, 0, 0, 1, 2'd1);
        repeat (5) @(negedge clk);
        pulse(0, 0, 0, 1, 2'd3);
        drain(0, 200);
        chk("t2_frame_hold", 32'(cf_a), 0);
        chk("t2_line", 32'(li_a), 2);
        k = log_addr_a.size();
        push_line(0, 1, 0);
        pulse(0, 1, 0, 0, 0);
        drain(0, 200);
        chk("t2_frame_new", 32'(cf_a), 1);
        chk("t2_addr", log_addr_a[k], 32'h0040_0000);

        // framestart during WAIT_LO of burst 2 of line 5
        for (int l = 1; l <= 4; l++) begin
            push_line(0, 1, l);
            pulse(0, 0, 1, 0, 0);
            drain(0, 200);
        end
        chk("t3_line5", 32'(li_a), 5);
        k = log_addr_a.size();
        push_one(0, 32'h0040_0000 + 32'd5 * 32'd5120, 32'd256);
        push_one(0, 32'h0040_0000 + 32'd5 * 32'd5120 + 32'h400, 32'd256);
        pulse(0, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (log_addr_a.size() >= k + 2) begin n = 1; break; end
        end
        if (n == 0) bound_fail("t3_wait_burst2");
        repeat (3) @(negedge clk);
        push_line(0, 1, 0);
        pulse(0, 1, 0, 0, 0);
        drain(0, 200);
        chk("t3_gap", 32'(log_cyc_a[k+2] - log_cyc_a[k+1]), 13);
        chk("t3_addr", log_addr_a[k+2], 32'h0040_0000);
        chk("t3_overrun", 32'(ov_a), 0);
        chk("t3_line", 32'(li_a), 1);

        // framestart, prefetch and wr_frame_done(0) in one cycle
        push_line(0, 0, 0);
        pulse(0, 1, 1, 1, 2'd0);
        wait_kick(0, 10, n);
        chk("t4_latency", 32'(n), 2);
        drain(0, 200);
        chk("t4_frame", 32'(cf_a), 0);
        chk("t4_overrun", 32'(ov_a), 0);
        chk("t4_line", 32'(li_a), 1);

        // Two prefetches while the reader holds busy
        push_line(0, 0, 1);
        hold_a = 1;
        pulse(0, 0, 1, 0, 0);
        repeat (5) @(negedge clk);
        pulse(0, 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("t5_overrun_set", 32'(ov_a), 1);
        hold_a = 0;
        drain(0, 300);
        repeat (10) @(negedge clk);
        chk("t5_line", 32'(li_a), 2);
        chk("t5_overrun_sticky", 32'(ov_a), 1);

        // Reader never raises busy: timeout paces the bursts
        never_a = 1;
        k = log_addr_a.size();
        push_line(0, 0, 2);
        pulse(0, 0, 1, 0, 0);
        drain(0, 300);
        repeat (25) @(negedge clk);
        chk("t6_gap01", 32'(log_cyc_a[k+1] - log_cyc_a[k]), 18);
        chk("t6_gap34", 32'(log_cyc_a[k+4] - log_cyc_a[k+3]), 18);
        chk("t6_line", 32'(li_a), 3);

        // Asynchronous reset in the middle of a kick
        push_line(0, 0, 3);
        pulse(0, 0, 1, 0, 0);
        wait_kick(0, 10, n);
        rst = 0;
        #1;
        chk("t7_kick", 32'(kick_a), 0);
        chk("t7_line", 32'(li_a), 0);
        chk("t7_overrun", 32'(ov_a), 0);
        chk("t7_addr", addr_a, 0);
        exp_a.delete();
        @(posedge clk); #1;
        rst = 1;
        never_a = 0;

        // BPP=2, Y_SIZE=4, single buffer
        pulse(1, 0, 0, 1, 2'd1);
        push_line(1, 0, 0);
        pulse(1, 1, 0, 0, 0);
        drain(1, 200);
        chk("b_frame", 32'(cf_b), 0);
        chk("b_line1", 32'(li_b), 1);
        k = 0;
        for (int l = 1; l <= 3; l++) begin
            if (l == 3) k = log_addr_b.size();
            push_line(1, 0, l);
            pulse(1, 0, 1, 0, 0);
            drain(1, 200);
        end
        chk("b_addr0", log_addr_b[k], 32'h1E00);
        chk("b_num0", log_num_b[k], 32'd256);
        chk("b_num1", log_num_b[k+1], 32'd256);
        chk("b_num2", log_num_b[k+2], 32'd128);
        chk("b_addr2", log_addr_b[k+2], 32'h2600);
        chk("b_line4", 32'(li_b), 4);
        pulse(1, 0, 1, 0, 0);
        repeat (20) @(negedge clk);
        chk("b_past_end_line", 32'(li_b), 4);
        chk("b_past_end_overrun", 32'(ov_b), 0);

        chk("a_queue_left", 32'(exp_a.size()), 0);
        chk("b_queue_left", 32'(exp_b.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_frame_fetcher.md
Name: hdmi_frame_fetcher

Overview:
- Parametrised DRAM read scheduler for the HDMI output path; runs in the pixel-clock domain.
- Turns framestart/prefetch_line pulses from the timing generator into chunked kick/read_addr/read_num requests for the DRAM reader.
- Supports N-buffer frame rotation, configurable pixel size and maximum burst length.
- Adds overrun detection, which the single-buffer fixed-line predecessor lacked.

Parameters:
- X_SIZE, 1280, active pixels per line
- Y_SIZE, 720, active lines per frame
- BPP, 4, bytes per pixel stored in DRAM (1, 2 or 4); X_SIZE*BPP must be a multiple of 4
- MAX_BURST, 256, maximum 32-bit words per kick (power of two, ≥1)
- NUM_FRAMES, 2, frame buffers in DRAM (1..4)
- BASE_ADDR, 32'h0000_0000, byte address of frame buffer 0
- FRAME_STRIDE, 32'h0040_0000, byte distance between frame buffers

Ports:
- clk  input  1  pixel clock; sole clock
- rst  input  1  asynchronous, active-low reset
- framestart  input  1  one-cycle pulse at frame start
- prefetch_line  input  1  one-cycle pulse requesting the next line
- wr_frame_done  input  1  pulse: the writer finished the buffer given by wr_frame
- wr_frame  input  2  index of the completed buffer
- kick  output  1  one-cycle request strobe to the DRAM reader
- busy  input  1  DRAM reader busy; already synchronised to clk
- read_addr  output  32  byte address of the burst
- read_num  output  32  words in the burst
- cur_frame  output  2  buffer being scanned out
- line_idx  output  12  line currently being fetched
- overrun  output  1  sticky: prefetch lost; cleared only by reset

Behaviour:
- Reset (asynchronous assert, synchronous release) clears all outputs to 0 and puts the FSM in IDLE.
- LINE_WORDS = X_SIZE*BPP/4. LINE_BYTES = LINE_WORDS*4.
- Address = BASE_ADDR + cur_frame*FRAME_STRIDE + line_idx*LINE_BYTES + word_off*4. Arithmetic is 32-bit; wrap-around is ignored.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if a line is pending and line_idx < Y_SIZE, go to ISSUE. word_off = 0.
  - ISSUE: kick=1 for exactly one cycle. read_num = min(LINE_WORDS-word_off, MAX_BURST). read_addr is valid the same cycle and held until the next ISSUE. Then go to WAIT_HI.
  - WAIT_HI: wait for busy=1, then go to WAIT_LO. If busy has not risen after 16 cycles, go to WAIT_LO anyway, covering a reader that completes combinationally.
  - WAIT_LO: wait for busy=0. Then word_off += read_num. If word_off < LINE_WORDS, go to ISSUE. Otherwise line_idx++, clear pending, go to IDLE.
- Latency: pending in IDLE → kick two cycles later. Between bursts of one line: one cycle from busy falling to the next kick.
- Pending is a 1-deep flag.
  - prefetch_line sets it.
  - prefetch_line while pending is already set sets overrun; the request is dropped.
  - prefetch_line with line_idx ≥ Y_SIZE is ignored, and does not set overrun.
- framestart:
  - line_idx := 0 and pending := 1, so line 0 is fetched automatically.
  - cur_frame := latest_done if any wr_frame_done was seen since the last framestart; otherwise cur_frame is unchanged.
  - If it arrives mid-burst, the in-flight burst completes with its old address (a DRAM burst is never aborted). The FSM then goes to IDLE and the remaining words of the old line are discarded; overrun is not set.
- framestart and prefetch_line in the same cycle: framestart wins; the prefetch is absorbed into the line-0 pending.
- wr_frame_done latches wr_frame into latest_done, which is only applied at the next framestart (tear-free).
  - If it coincides with framestart, the new value applies at that same framestart.
  - wr_frame values ≥ NUM_FRAMES are ignored.
- With NUM_FRAMES=1, cur_frame stays 0.

Decomposition:
- Shared package hdmi_pkg holds:
  - FSM state encoding
  - LINE_WORDS/LINE_BYTES computation functions
  - the 16-cycle busy timeout constant
  - the default X/Y/BPP constants shared with the timing generator
- One natural sub-module, hdmi_burst_split: holds word_off and the min() computation. It outputs read_num and a last-burst flag, and advances on a done strobe.

Test Plan:
- X_SIZE=1280, BPP=4, MAX_BURST=256, reader busy 10 cycles per kick; framestart → 5 kicks: read_addr 0x0, 0x400, 0x800, 0xC00, 0x1000, each read_num=256; then line_idx=1.
- BPP=2, X_SIZE=1280, MAX_BURST=256: prefetch_line for line 3 → 3 kicks, read_num 256, 256, 128; first read_addr=3*2560=0x1E00.
- Two prefetch_line pulses while busy is held high → overrun=1 and stays 1 until rst=0; exactly one extra line is fetched.
- NUM_FRAMES=2, FRAME_STRIDE=0x400000: wr_frame_done with wr_frame=1 mid-frame, then framestart → cur_frame=1, first read_addr=0x400000. Before that framestart, all addresses stay in frame 0.
- framestart during the WAIT_LO of burst 2 of line 5 → no new kick until busy falls; next kick has read_addr at line 0 with word_off=0; overrun=0.
- Reader never asserts busy → kick repeats every 18 cycles (ISSUE + 16 WAIT_HI + 1 WAIT_LO); line completes. Assert rst mid-burst → kick=0, line_idx=0, overrun=0 immediately, without a clock edge.
